// File: rtl/bus_poll_scheduler.sv
// Round-robin poll scheduler for the serial sensor bus: address out, 2-byte reply in, results to a FIFO.
// Optional POLL_RETRY_EN: one retry of the same node before a failure is counted.
module bus_poll_scheduler #(
  parameter int unsigned N_NODES     = 4,
  parameter logic [7:0]  KEY         = 8'h37,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned GAP_CYC     = 16,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [N_NODES-1:0] node_mask,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  input  logic               rd_req,
  output logic [11:0]        rd_data,
  output logic               rd_valid,
  output logic               alarm,
  output logic [3:0]         alarm_node,
  input  logic               alarm_clr,
  output logic [7:0]         err_count
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int unsigned NW = (N_NODES > 1) ? $clog2(N_NODES) : 1;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_SELECT, S_SEND, S_WAIT_B0, S_WAIT_B1,
    S_CHECK, S_ALARM, S_PUSH, S_ERR, S_GAP
  } state_t;

  state_t          state, state_next, fail_next;
  logic [3:0]      ptr, sel_ptr, ptr_inc;
  logic [TW-1:0]   timer;
  logic [GW-1:0]   gap_cnt;
  logic [7:0]      b0, b1;
  logic            mask_any, timeout, gap_done, pkt_alarm, pkt_ok;
  logic            fifo_full, push, pop;
  logic [11:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  assign mask_any  = |node_mask;
  assign timeout   = (timer == TW'(TIMEOUT_CYC));
  assign gap_done  = (gap_cnt == GW'(GAP_CYC - 1));
  assign pkt_alarm = (b0 == KEY) && (b1 == 8'h00);
  assign pkt_ok    = (b1 == (b0 ^ KEY));
  assign ptr_inc   = (ptr == 4'(N_NODES - 1)) ? 4'd0 : ptr + 4'd1;
  assign fifo_full = (count == CW'(FIFO_DEPTH));
  assign rd_valid  = (count != '0);
  assign rd_data   = rd_valid ? mem[rd_ptr] : 12'h000;
  assign pop       = rd_req && rd_valid;
  // A full FIFO still accepts the write when the head is popped in the same cycle
  assign push      = (state == S_PUSH) && (!fifo_full || pop);

  // First enabled node at or after ptr, wrapping; lowest offset wins
  always_comb begin
    int idx;
    sel_ptr = ptr;
    idx     = 0;
    for (int i = int'(N_NODES) - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= int'(N_NODES)) idx = idx - int'(N_NODES);
      if (node_mask[NW'(idx)]) sel_ptr = 4'(idx);
    end
  end

`ifdef POLL_RETRY_EN
  logic retried;

  always_comb begin
    fail_next = retried ? S_ERR : S_SEND;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        retried <= 1'b0;
    else if (state == S_SELECT)                       retried <= 1'b0;
    else if (state != S_SEND && state_next == S_SEND) retried <= 1'b1;
  end
`else
  always_comb begin
    fail_next = S_ERR;
  end
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:    if (enable && mask_any) state_next = S_SELECT;
      S_SELECT:  state_next = mask_any ? S_SEND : S_IDLE;
      S_SEND:    if (tx_ready) state_next = S_WAIT_B0;
      S_WAIT_B0: if (rx_valid) state_next = S_WAIT_B1;
                 else if (timeout) state_next = fail_next;
      S_WAIT_B1: if (rx_valid) state_next = S_CHECK;
                 else if (timeout) state_next = fail_next;
      S_CHECK:   if (pkt_alarm) state_next = S_ALARM;
                 else if (pkt_ok) state_next = S_PUSH;
                 else state_next = fail_next;
      S_ALARM:   state_next = S_GAP;
      S_PUSH:    if (push) state_next = S_GAP;
      S_ERR:     state_next = S_GAP;
      S_GAP:     if (gap_done) state_next = (enable && mask_any) ? S_SELECT : S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    tx_valid = (state == S_SEND);
    tx_data  = tx_valid ? (8'(ptr) + 8'd1) : 8'h00;
  end

  // Poll datapath: pointer, timers, reply bytes, status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr        <= 4'd0;
      timer      <= '0;
      gap_cnt    <= '0;
      b0         <= 8'h00;
      b1         <= 8'h00;
      err_count  <= 8'h00;
      alarm      <= 1'b0;
      alarm_node <= 4'd0;
    end else begin
      if (state == S_SELECT) ptr <= sel_ptr;
      else if (state == S_GAP && gap_done) ptr <= ptr_inc;

      if ((state == S_WAIT_B0 || state == S_WAIT_B1) && !rx_valid) timer <= timer + TW'(1);
      else timer <= '0;

      if (state == S_GAP) gap_cnt <= gap_cnt + GW'(1);
      else gap_cnt <= '0;

      if (state == S_WAIT_B0 && rx_valid) b0 <= rx_data;
      if (state == S_WAIT_B1 && rx_valid) b1 <= rx_data;

      if (state == S_ERR && err_count != 8'hFF) err_count <= err_count + 8'd1;

      // A new alarm event beats a simultaneous clear
      if (state == S_ALARM && (!alarm || alarm_clr)) begin
        alarm      <= 1'b1;
        alarm_node <= ptr;
      end else if (alarm_clr) begin
        alarm      <= 1'b0;
        alarm_node <= 4'd0;
      end
    end
  end

  // Result FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {ptr, b0};
  end

endmodule
